// File: rtl/axi_outstanding_tracker.sv
// axi_outstanding_tracker
//   Counts in-flight AXI transactions per ID and overall, gates new issues
//   against a per-ID cap and a global cap, and provides a drain/fence
//   handshake that waits for every outstanding transaction to complete.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_valid_i, req_id_i   new transaction request and its ID
//   req_ready_o             issue permitted (combinational from registered counts)
//   rsp_valid_i, rsp_id_i   final response (B or RLAST) and its ID
//   drain_req_i             fence request, sampled only while idle
//   drain_ack_o             one-cycle pulse once everything has drained
//   busy_o                  global count non-zero
//   total_cnt_o             registered global in-flight count
//   err_o                   sticky protocol error
//
// Optional feature
//   AXI_OUTSTANDING_TRACKER_ERR_CHECK_EN: when defined, err_o flags responses to
//   IDs with nothing outstanding and requests carrying an out-of-range ID.
//   When undefined err_o is tied low and no error logic exists.
module axi_outstanding_tracker #(
   parameter int unsigned NrIds          = 16,
   parameter int unsigned IdWidth        = 4,
   parameter int unsigned MaxOutstanding = 7,
   parameter int unsigned MaxPerId       = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 req_valid_i,
   input  logic [IdWidth-1:0]                   req_id_i,
   output logic                                 req_ready_o,
   input  logic                                 rsp_valid_i,
   input  logic [IdWidth-1:0]                   rsp_id_i,
   input  logic                                 drain_req_i,
   output logic                                 drain_ack_o,
   output logic                                 busy_o,
   output logic [$clog2(MaxOutstanding+1)-1:0] total_cnt_o,
   output logic                                 err_o
);

   localparam int unsigned CntW = $clog2(MaxPerId + 1);
   localparam int unsigned TotW = $clog2(MaxOutstanding + 1);
   localparam int unsigned IdxW = (NrIds > 1) ? $clog2(NrIds) : 1;

   localparam logic [CntW-1:0]  CntMax  = CntW'(MaxPerId);
   localparam logic [CntW-1:0]  CntOne  = CntW'(1);
   localparam logic [TotW-1:0]  TotMax  = TotW'(MaxOutstanding);
   localparam logic [TotW-1:0]  TotOne  = TotW'(1);
   localparam logic [IdWidth:0] IdLimit = (IdWidth + 1)'(NrIds);

   typedef enum logic [1:0] {StIdle, StDrain, StAck} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q [NrIds];
   logic [CntW-1:0]     cnt_d [NrIds];
   logic [TotW-1:0]     total_q, total_d;

   logic                req_in_range, rsp_in_range;
   logic [IdxW-1:0]     req_idx, rsp_idx;
   logic                issue, rsp_ok;

   // Out-of-range IDs are steered to index 0 so the array is never indexed
   // past its end; the range flag keeps them from having any effect.
   always_comb begin
      req_in_range = {1'b0, req_id_i} < IdLimit;
      rsp_in_range = {1'b0, rsp_id_i} < IdLimit;
      req_idx      = req_in_range ? IdxW'(req_id_i) : '0;
      rsp_idx      = rsp_in_range ? IdxW'(rsp_id_i) : '0;

      req_ready_o  = (total_q < TotMax) && (cnt_q[req_idx] < CntMax) &&
                     (state_q == StIdle) && req_in_range;
      issue        = req_valid_i && req_ready_o;
      // Responses with nothing outstanding are dropped, never underflow.
      rsp_ok       = rsp_valid_i && rsp_in_range && (cnt_q[rsp_idx] != '0);
   end

   // Per-ID counters: a same-ID issue and response cancel out.
   always_comb begin
      for (int unsigned i = 0; i < NrIds; i++) begin
         cnt_d[i] = cnt_q[i];
         if (issue && (req_idx == IdxW'(i)) && !(rsp_ok && (rsp_idx == IdxW'(i)))) begin
            cnt_d[i] = cnt_q[i] + CntOne;
         end else if (rsp_ok && (rsp_idx == IdxW'(i)) && !(issue && (req_idx == IdxW'(i)))) begin
            cnt_d[i] = cnt_q[i] - CntOne;
         end
      end
   end

   always_comb begin
      total_d = total_q;
      if (issue && !rsp_ok) begin
         total_d = total_q + TotOne;
      end else if (rsp_ok && !issue) begin
         total_d = total_q - TotOne;
      end
   end

   // Drain FSM; DRAIN looks at the registered total, which gives the
   // two-cycle minimum latency from request to acknowledge.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (drain_req_i) state_d = StDrain;
         StDrain: if (total_q == '0) state_d = StAck;
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         total_q <= '0;
         for (int unsigned i = 0; i < NrIds; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         total_q <= total_d;
         for (int unsigned i = 0; i < NrIds; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign drain_ack_o = (state_q == StAck);
   assign busy_o      = (total_q != '0);
   assign total_cnt_o = total_q;

`ifdef AXI_OUTSTANDING_TRACKER_ERR_CHECK_EN
   logic err_q;
   logic err_set;

   assign err_set = (rsp_valid_i && !rsp_ok) || (req_valid_i && !req_in_range);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_outstanding_tracker.sv
`timescale 1ns/10ps
module tb_axi_outstanding_tracker;

   localparam int NrIds   = 16;
   localparam int IdWidth = 4;
   localparam int MaxOut  = 7;
   localparam int MaxPer  = 4;
`ifdef AXI_OUTSTANDING_TRACKER_ERR_CHECK_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               req_valid = 1'b0;
   logic [IdWidth-1:0] req_id = '0;
   logic               req_ready;
   logic               rsp_valid = 1'b0;
   logic [IdWidth-1:0] rsp_id = '0;
   logic               drain_req = 1'b0;
   logic               drain_ack;
   logic               busy;
   logic [2:0]         total_cnt;
   logic               err;

   int checks = 0;
   int failures = 0;

   // Reference model: plain counts plus a drain phase (0 idle, 1 waiting, 2 ack).
   int  m_cnt [NrIds];
   int  m_tot;
   int  m_phase;
   bit  m_err;

   always #5 clk = ~clk;

   axi_outstanding_tracker #(
      .NrIds(NrIds), .IdWidth(IdWidth), .MaxOutstanding(MaxOut), .MaxPerId(MaxPer)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_id_i(req_id), .req_ready_o(req_ready),
      .rsp_valid_i(rsp_valid), .rsp_id_i(rsp_id),
      .drain_req_i(drain_req), .drain_ack_o(drain_ack),
      .busy_o(busy), .total_cnt_o(total_cnt), .err_o(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_ready(input int id);
      return (m_tot < MaxOut) && (id < NrIds) && (m_cnt[id] < MaxPer) && (m_phase == 0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NrIds; i++) m_cnt[i] = 0;
      m_tot   = 0;
      m_phase = 0;
      m_err   = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, "_total"}, 32'(total_cnt), 32'(m_tot));
      chk({tag, "_busy"},  32'(busy),      32'(m_tot != 0));
      chk({tag, "_ack"},   32'(drain_ack), 32'(m_phase == 2));
      chk({tag, "_err"},   32'(err),       32'(m_err));
   endtask

   // One clock: drive, check combinational ready, clock, update model, check state.
   task automatic step(input bit v, input int id, input bit rv, input int rid, input bit dr);
      bit issue, rsp_ok;
      int old_tot;
      req_valid = v;  req_id = IdWidth'(id);
      rsp_valid = rv; rsp_id = IdWidth'(rid);
      drain_req = dr;
      #1;
      chk("ready", 32'(req_ready), 32'(model_ready(id)));
      issue   = v && model_ready(id);
      rsp_ok  = rv && (rid < NrIds) && (m_cnt[rid % NrIds] > 0);
      old_tot = m_tot;
      @(posedge clk);
      if (issue) begin m_cnt[id]++; m_tot++; end
      if (rsp_ok) begin m_cnt[rid]--; m_tot--; end
      if (m_phase == 0) m_phase = dr ? 1 : 0;
      else if (m_phase == 1) m_phase = (old_tot == 0) ? 2 : 1;
      else m_phase = 0;
      if (ErrEn && ((rv && !rsp_ok) || (v && id >= NrIds))) m_err = 1'b1;
      #1;
      req_valid = 1'b0; rsp_valid = 1'b0; drain_req = 1'b0;
      check_regs("step");
   endtask

   task automatic peek_ready(input string tag, input int id, input bit exp);
      req_valid = 1'b0; rsp_valid = 1'b0; drain_req = 1'b0;
      req_id = IdWidth'(id);
      #0.1;
      chk(tag, 32'(req_ready), 32'(exp));
      chk({tag, "_model"}, 32'(req_ready), 32'(model_ready(id)));
   endtask

   task automatic do_reset();
      req_valid = 1'b0; rsp_valid = 1'b0; drain_req = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_total", 32'(total_cnt), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_ack",   32'(drain_ack), 0);
      chk("rst_err",   32'(err), 0);
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_regs("post_rst");
   endtask

   initial begin
      model_reset();
      #2;
      do_reset();
      for (int i = 0; i < NrIds; i += 5) peek_ready("rst_ready", i, 1'b1);

      // Four issues on ID 3 saturate that ID only.
      for (int i = 0; i < 4; i++) step(1, 3, 0, 0, 0);
      chk("r031_total", 32'(total_cnt), 4);
      peek_ready("r031_ready3", 3, 1'b0);
      peek_ready("r031_ready5", 5, 1'b1);

      // Global cap.
      do_reset();
      for (int i = 0; i < 7; i++) step(1, i, 0, 0, 0);
      chk("r032_total", 32'(total_cnt), 7);
      for (int i = 0; i < NrIds; i++) peek_ready("r032_full", i, 1'b0);
      step(0, 0, 1, 2, 0);
      chk("r032_total_after_rsp", 32'(total_cnt), 6);
      peek_ready("r032_ready_after_rsp", 2, 1'b1);

      // Same-ID issue+response, and a stray response.
      do_reset();
      step(1, 1, 0, 0, 0);
      step(1, 1, 1, 1, 0);
      chk("r033_same_id_total", 32'(total_cnt), 1);
      step(0, 0, 1, 9, 0);
      chk("r033_stray_total", 32'(total_cnt), 1);
      chk("r033_err", 32'(err), 32'(ErrEn));
      step(0, 0, 1, 1, 0);
      chk("r033_cnt1_was_one", 32'(total_cnt), 0);

      // Drain with two outstanding.
      do_reset();
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      peek_ready("r034_blocked", 4, 1'b0);
      step(1, 4, 1, 0, 0);
      step(0, 0, 1, 1, 0);
      chk("r034_ack_not_yet", 32'(drain_ack), 0);
      step(0, 0, 0, 0, 0);
      chk("r034_ack", 32'(drain_ack), 1);
      step(0, 0, 0, 0, 1);
      chk("r034_ack_once", 32'(drain_ack), 0);
      peek_ready("r034_ready_ignored_drain", 4, 1'b1);

      // Drain when empty: two-cycle latency.
      do_reset();
      step(0, 0, 0, 0, 1);
      chk("r035_n1", 32'(drain_ack), 0);
      step(0, 0, 0, 0, 0);
      chk("r035_n2", 32'(drain_ack), 1);
      step(0, 0, 0, 0, 0);
      chk("r035_n3", 32'(drain_ack), 0);

      // Reset mid-drain.
      do_reset();
      for (int i = 0; i < 3; i++) step(1, i + 8, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      chk("r036_pre_total", 32'(total_cnt), 3);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0);
         chk("r036_no_ack", 32'(drain_ack), 0);
      end
      peek_ready("r036_idle", 6, 1'b1);

      // Randomized traffic against the model.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 7),
                 $urandom_range(0, 99) < 45, $urandom_range(0, 7),
                 $urandom_range(0, 29) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_outstanding_tracker.md
AXI_OUTSTANDING_TRACKER -- requirements
Module: axi_outstanding_tracker

Interface
REQ-001 SHALL have parameter NrIds, default 16, meaning number of tracked AXI IDs (one counter each).
REQ-002 SHALL have parameter IdWidth, default 4, meaning ID field width, with NrIds <= 2**IdWidth.
REQ-003 SHALL have parameter MaxOutstanding, default 7, meaning global cap on in-flight transactions (1..255).
REQ-004 SHALL have parameter MaxPerId, default 4, meaning per-ID cap (1..MaxOutstanding).
REQ-005 SHALL have the following ports: clk_i, input, 1, single clock; all state is updated on its rising edge.
REQ-006 SHALL have the following port: rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have the following ports: req_valid_i, input, 1, new transaction request; req_id_i, input, IdWidth, ID of the request; req_ready_o, output, 1, issue permitted.
REQ-008 SHALL have the following ports: rsp_valid_i, input, 1, final response (B or RLAST) seen; rsp_id_i, input, IdWidth, ID of the response.
REQ-009 SHALL have the following ports: drain_req_i, input, 1, fence/drain request; drain_ack_o, output, 1, one-cycle drain-complete pulse.
REQ-010 SHALL have the following ports: busy_o, output, 1, total count non-zero; total_cnt_o, output, $clog2(MaxOutstanding+1), global in-flight count; err_o, output, 1, sticky protocol error.

Function
REQ-011 Issue SHALL occur when req_valid_i && req_ready_o; it increments cnt[req_id_i] and the total by 1 at the next edge.
REQ-012 req_ready_o SHALL be combinational: total < MaxOutstanding AND cnt[req_id_i] < MaxPerId AND state == IDLE AND req_id_i < NrIds.
REQ-013 A response SHALL decrement cnt[rsp_id_i] and the total by 1 when rsp_valid_i is high and cnt[rsp_id_i] > 0.
REQ-014 A response to an ID whose count is 0 (or an ID >= NrIds) SHALL leave all counts unchanged, with no underflow.
REQ-015 A simultaneous issue and response on the same ID SHALL leave that ID's count and the total unchanged.
REQ-016 A simultaneous issue and response on different IDs SHALL apply the +1 and -1 independently, leaving the total unchanged.
REQ-017 Issue SHALL be permitted in the same cycle as a response that frees the last slot only from the next cycle on; req_ready_o uses registered counts.
REQ-018 Drain FSM states SHALL be IDLE, DRAIN and ACK.
REQ-019 In IDLE, drain_req_i high SHALL cause a transition to DRAIN.
REQ-020 In DRAIN, a registered total == 0 SHALL cause a transition to ACK.
REQ-021 In ACK, the FSM SHALL move unconditionally to IDLE.
REQ-022 drain_ack_o SHALL be 1 only in ACK, for exactly one cycle; the minimum latency is 2 cycles after drain_req_i is sampled, even when already empty.
REQ-023 drain_req_i SHALL be ignored outside IDLE, and responses SHALL continue to be counted in DRAIN and ACK.
REQ-024 busy_o SHALL equal (total != 0), and total_cnt_o SHALL be the registered total.

Reset
REQ-025 Asserting rst_ni low SHALL immediately clear all counters and the total, set the FSM to IDLE, and clear err_o.
REQ-026 Reset mid-drain SHALL abort the drain, with no drain_ack_o pulse generated.
REQ-027 After reset, req_ready_o SHALL be 1 for any valid ID, busy_o SHALL be 0, and drain_ack_o SHALL be 0.

Configuration
REQ-028 The macro AXI_OUTSTANDING_TRACKER_ERR_CHECK_EN SHALL control error checking.
REQ-029 When AXI_OUTSTANDING_TRACKER_ERR_CHECK_EN is defined, err_o SHALL set one cycle after a response to a zero-count or out-of-range ID, or after req_valid_i with an out-of-range ID, and stay set until reset.
REQ-030 When AXI_OUTSTANDING_TRACKER_ERR_CHECK_EN is undefined, err_o SHALL be tied to 0 and no error logic shall be synthesised; counting behaviour SHALL be identical in both builds.

Verification
REQ-031 After reset, issue ID 3 four times -> cnt[3] = 4, req_ready_o = 0 for ID 3, req_ready_o = 1 for ID 5, total_cnt_o = 4.
REQ-032 Issue 7 transactions across IDs 0-6 -> total_cnt_o = 7, req_ready_o = 0 for every ID; one response on ID 2 -> req_ready_o = 1 on the next cycle.
REQ-033 With cnt[1] = 1, issue and respond on ID 1 in the same cycle -> cnt[1] = 1 and total unchanged; a response on ID 9 with count 0 -> counts unchanged, err_o = 1 only when the macro is defined.
REQ-034 With 2 outstanding, pulse drain_req_i -> req_ready_o = 0; respond to both -> drain_ack_o high for exactly one cycle, then IDLE with req_ready_o = 1.
REQ-035 With 0 outstanding, drain_req_i sampled at cycle N -> drain_ack_o = 1 at cycle N+2 only.
REQ-036 Assert rst_ni low during DRAIN with 3 outstanding -> total_cnt_o = 0 immediately, no drain_ack_o, FSM in IDLE.
